fetch_bus_ctrl: RTL



---
 rtl/fetch_bus_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_bus_ctrl.sv
//-----------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module      : fetch_bus_ctrl                                            |
// | Description : Instruction-fetch bus master for the single-port ROM.     |
// |               Holds the PC, issues one active-low cs_/as_ read per      |
// |               instruction, captures the returned word into an           |
// |               instruction register with a valid/ready handshake,        |
// |               handles branch redirects, drops stale responses and       |
// |               flags bus timeouts with a sticky error.                   |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   fetch_en              1 = fetch continuously, 0 = finish access then idle
//   br_taken, br_addr     one-cycle redirect strobe and target
//   rom_cs_, rom_as_      ROM chip select / address strobe (active low)
//   rom_addr              ROM word address (always the current PC)
//   rom_rd_data, rom_rdy_ ROM read data, valid while rom_rdy_ is low
//   if_pc, if_insn        fetched instruction and its address
//   if_valid, id_ready    fetch-to-decode handshake
//   bus_err               sticky timeout flag, cleared only by reset
//-----------------------------------------------------------------------------
`default_nettype none

module fetch_bus_ctrl #(
  parameter int              ADDR_W   = 11,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              rom_cs_,
  output logic              rom_as_,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  input  logic              rom_rdy_,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_valid,
  input  logic              id_ready,
  output logic              bus_err
);

  localparam int                c_CNT_W   = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [ADDR_W-1:0]   r_pc,       w_pc_nxt;
  logic [ADDR_W-1:0]   r_if_pc,    w_if_pc_nxt;
  logic [DATA_W-1:0]   r_if_insn,  w_if_insn_nxt;
  logic                r_if_valid, w_if_valid_nxt;
  logic                r_discard,  w_discard_nxt;
  logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nxt;
  logic                r_bus_err,  w_bus_err_nxt;
  logic                w_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_if_insn  <= '0;
      r_if_valid <= 1'b0;
      r_discard  <= 1'b0;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_insn  <= w_if_insn_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_discard  <= w_discard_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bus_err  <= w_bus_err_nxt;
    end
  end

  // A response arriving in the same cycle as a redirect belongs to the old
  // stream, so a live branch counts as a pending discard.
  assign w_drop = r_discard | br_taken;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_pc_nxt    = r_if_pc;
    w_if_insn_nxt  = r_if_insn;
    w_if_valid_nxt = r_if_valid;
    w_discard_nxt  = r_discard;
    w_cnt_nxt      = r_cnt;
    w_bus_err_nxt  = r_bus_err;

    case (r_state)
      S_IDLE: begin
        if (br_taken) begin
          w_pc_nxt       = br_addr;
          w_if_valid_nxt = 1'b0;
        end
        if (fetch_en) w_state_nxt = S_REQ;
      end

      S_REQ: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
        if (br_taken) begin
          w_pc_nxt       = br_addr;
          w_if_valid_nxt = 1'b0;
          w_discard_nxt  = 1'b1;
        end
      end

      S_WAIT: begin
        if (br_taken) begin
          w_pc_nxt       = br_addr;
          w_if_valid_nxt = 1'b0;
          w_discard_nxt  = 1'b1;
        end
        if (!rom_rdy_) begin
          if (w_drop) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = fetch_en ? S_REQ : S_IDLE;
          end else begin
            w_if_insn_nxt  = rom_rd_data;
            w_if_pc_nxt    = r_pc;
            w_if_valid_nxt = 1'b1;
            w_pc_nxt       = r_pc + 1'b1;
            w_state_nxt    = S_HOLD;
          end
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt   = S_ERR;
          w_bus_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_HOLD: begin
        // A redirect wins over the handshake: the held word is thrown away.
        if (br_taken) begin
          w_pc_nxt       = br_addr;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = fetch_en ? S_REQ : S_IDLE;
        end else if (r_if_valid && id_ready) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = fetch_en ? S_REQ : S_IDLE;
        end
      end

      S_ERR: begin
        w_if_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rom_cs_  = (r_state != S_REQ);
  assign rom_as_  = (r_state != S_REQ);
  assign rom_addr = r_pc;
  assign if_pc    = r_if_pc;
  assign if_insn  = r_if_insn;
  assign if_valid = r_if_valid;
  assign bus_err  = r_bus_err;

endmodule

`default_nettype wire
